// File: rtl/booth_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// booth_ctrl_pkg
// Shared definitions for the Booth multiplier arbiter slice: default operand
// width and multiplier latency, and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package booth_ctrl_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_LATENCY = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin selector. Purely combinational.
//   req   [1:0]  request bits
//   ptr          priority pointer; selects the winner when both request
//   grant [1:0]  one-hot grant (all zero when nothing requests)
// A lone request always wins regardless of the pointer.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// -----------------------------------------------------------------------------
// booth_mul_arbiter
// Shares one external Booth multiplier between two requesters.
//   clock, reset_n      system clock, synchronous active-low reset
//   req[1:0]            per-requester request, held until ack
//   mpd0/mpr0/mpd1/mpr1 requester operands (two's complement)
//   ack[1:0]            one-cycle completion pulse per requester
//   res0/res1           last product delivered to each requester
//   busy                high whenever the controller is not idle
//   mul_enable          multiplier enable (high for LATENCY cycles per op)
//   mul_mpd/mul_mpr     operands presented to the multiplier
//   mul_res             multiplier product
// Sequence per operation: IDLE (grant, capture) -> LOAD (enable low, the
// multiplier reloads) -> RUN (LATENCY cycles) -> DONE (ack) -> IDLE.
// -----------------------------------------------------------------------------
module booth_mul_arbiter
    import booth_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           req,
    input  logic [WIDTH-1:0]     mpd0,
    input  logic [WIDTH-1:0]     mpr0,
    input  logic [WIDTH-1:0]     mpd1,
    input  logic [WIDTH-1:0]     mpr1,
    output logic [1:0]           ack,
    output logic [2*WIDTH-1:0]   res0,
    output logic [2*WIDTH-1:0]   res1,
    output logic                 busy,
    output logic                 mul_enable,
    output logic [WIDTH-1:0]     mul_mpd,
    output logic [WIDTH-1:0]     mul_mpr,
    input  logic [2*WIDTH-1:0]   mul_res
);

    localparam int unsigned CW = $clog2(LATENCY + 1);

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               gnt_q, gnt_d;       // index of the granted requester
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         ack_q, ack_d;
    logic [2*WIDTH-1:0] res0_q, res0_d;
    logic [2*WIDTH-1:0] res1_q, res1_d;
    logic               mul_en_q, mul_en_d;
    logic [WIDTH-1:0]   mpd_q, mpd_d;
    logic [WIDTH-1:0]   mpr_q, mpr_d;

    logic [1:0]         grant;

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        res0_d   = res0_q;
        res1_d   = res1_q;
        mul_en_d = mul_en_q;
        mpd_d    = mpd_q;
        mpr_d    = mpr_q;

        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    gnt_d   = grant[1];
                    mpd_d   = grant[1] ? mpd1 : mpd0;
                    mpr_d   = grant[1] ? mpr1 : mpr0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d    = CW'(LATENCY);
                mul_en_d = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                // Counter is loaded with LATENCY on entry, so reaching 1 marks
                // the last enabled cycle; the product is taken on this edge.
                if (cnt_q == CW'(1)) begin
                    cnt_d    = '0;
                    mul_en_d = 1'b0;
                    ack_d    = gnt_q ? 2'b10 : 2'b01;
                    if (gnt_q) begin
                        res1_d = mul_res;
                    end else begin
                        res0_d = mul_res;
                    end
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                ptr_d   = ~gnt_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            gnt_q    <= 1'b0;
            cnt_q    <= '0;
            ack_q    <= '0;
            res0_q   <= '0;
            res1_q   <= '0;
            mul_en_q <= 1'b0;
            mpd_q    <= '0;
            mpr_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            res0_q   <= res0_d;
            res1_q   <= res1_d;
            mul_en_q <= mul_en_d;
            mpd_q    <= mpd_d;
            mpr_q    <= mpr_d;
        end
    end

    assign ack        = ack_q;
    assign res0       = res0_q;
    assign res1       = res1_q;
    assign busy       = (state_q != ST_IDLE);
    assign mul_enable = mul_en_q;
    assign mul_mpd    = mpd_q;
    assign mul_mpr    = mpr_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_booth_mul_arbiter
// Scoreboard bench: a transaction-level model pushes expected completions into
// a queue when it decides a grant; a negedge monitor pops and compares against
// the DUT outputs. The external multiplier is modelled here: it presents the
// correct product only on the final enabled cycle, a corrupted one otherwise.
// -----------------------------------------------------------------------------
module tb_booth_mul_arbiter;

    localparam int unsigned W   = 4;
    localparam int unsigned LAT = 5;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [1:0]       req;
    logic [W-1:0]     mpd0, mpr0, mpd1, mpr1;
    logic [1:0]       ack;
    logic [2*W-1:0]   res0, res1;
    logic             busy;
    logic             mul_enable;
    logic [W-1:0]     mul_mpd, mul_mpr;
    logic [2*W-1:0]   mul_res;

    always #5 clock = ~clock;

    booth_mul_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .mpd0       (mpd0),
        .mpr0       (mpr0),
        .mpd1       (mpd1),
        .mpr1       (mpr1),
        .ack        (ack),
        .res0       (res0),
        .res1       (res1),
        .busy       (busy),
        .mul_enable (mul_enable),
        .mul_mpd    (mul_mpd),
        .mul_mpr    (mul_mpr),
        .mul_res    (mul_res)
    );

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    // Multiplier model: product valid once enable has been high LAT cycles.
    int unsigned en_cnt = 0;
    always @(posedge clock) begin
        if (mul_enable) en_cnt <= en_cnt + 1;
        else            en_cnt <= 0;
    end
    assign mul_res = (mul_enable && en_cnt == LAT - 1) ? smul(mul_mpd, mul_mpr)
                                                        : (smul(mul_mpd, mul_mpr) ^ 8'h5A);

    // ---------------- counters and compare helper ----------------
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic           g;
        logic [2*W-1:0] prod;
        int unsigned    due;
    } op_t;

    op_t            exp_q[$];
    op_t            m_op;
    logic           m_pend = 1'b0;
    int unsigned    m_busy = 0;      // cycles the controller remains occupied
    logic           m_ptr  = 1'b0;
    logic [2*W-1:0] m_res0 = '0, m_res1 = '0;
    logic [W-1:0]   m_mpd  = '0, m_mpr = '0;

    always @(posedge clock) begin : model
        logic g;
        cyc++;
        if (!reset_n) begin
            m_busy = 0;
            m_ptr  = 1'b0;
            m_res0 = '0;
            m_res1 = '0;
            m_mpd  = '0;
            m_mpr  = '0;
            m_pend = 1'b0;
            exp_q.delete();
        end else if (m_busy != 0) begin
            m_busy--;
            if (m_pend && cyc == m_op.due) begin
                if (m_op.g) m_res1 = m_op.prod;
                else        m_res0 = m_op.prod;
                m_pend = 1'b0;
            end
        end else if (req != 2'b00) begin
            g      = (req == 2'b11) ? m_ptr : req[1];
            m_ptr  = ~g;
            m_mpd  = g ? mpd1 : mpd0;
            m_mpr  = g ? mpr1 : mpr0;
            // grant edge -> LOAD, LAT RUN cycles, then DONE (ack) -> IDLE
            m_op   = '{g, smul(m_mpd, m_mpr), cyc + LAT + 1};
            exp_q.push_back(m_op);
            m_pend = 1'b1;
            m_busy = LAT + 2;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin : monitor
        logic [1:0] exp_ack;
        exp_ack = '0;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            exp_ack = exp_q[0].g ? 2'b10 : 2'b01;
            void'(exp_q.pop_front());
        end
        chk("ack",        32'(ack),        32'(exp_ack));
        chk("res0",       32'(res0),       32'(m_res0));
        chk("res1",       32'(res1),       32'(m_res1));
        chk("busy",       32'(busy),       32'(m_busy != 0));
        chk("mul_enable", 32'(mul_enable), 32'(m_busy >= 2 && m_busy <= LAT + 1));
        chk("mul_mpd",    32'(mul_mpd),    32'(m_mpd));
        chk("mul_mpr",    32'(mul_mpr),    32'(m_mpr));
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input logic [1:0] r, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1);
        req  = r;
        mpd0 = a0;
        mpr0 = b0;
        mpd1 = a1;
        mpr1 = b1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(2'b00, '0, '0, '0, '0);
        cycles(3);
        reset_n = 1'b1;

        // requester 0 alone: 3*5
        drive(2'b01, 4'd3, 4'd5, 4'd0, 4'd0);
        cycles(LAT + 3);
        req = 2'b00;
        chk("s1_res0", 32'(res0), 32'h0F);
        chk("s1_res1", 32'(res1), 32'h00);

        // requester 1 alone: -3*2, then -8*-8
        drive(2'b10, 4'd0, 4'd0, 4'hD, 4'd2);
        cycles(LAT + 3);
        chk("s2_res1a", 32'(res1), 32'hFA);
        drive(2'b10, 4'd0, 4'd0, 4'h8, 4'h8);
        cycles(LAT + 3);
        req = 2'b00;
        chk("s2_res1b", 32'(res1), 32'h40);
        chk("s2_res0",  32'(res0), 32'h0F);
        cycles(2);

        // both requesting from reset: alternating grants
        reset_n = 1'b0;
        drive(2'b11, 4'd2, 4'd7, 4'hF, 4'd6);
        cycles(2);
        reset_n = 1'b1;
        cycles(4 * (LAT + 3));
        req = 2'b00;
        cycles(2);
        chk("s3_res0", 32'(res0), 32'h0E);
        chk("s3_res1", 32'(res1), 32'hFA);

        // reset during RUN aborts the operation
        drive(2'b01, 4'd7, 4'd7, 4'd0, 4'd0);
        cycles(4);
        reset_n = 1'b0;
        cycles(1);
        reset_n = 1'b1;
        chk("s4_busy", 32'(busy), 32'h0);
        chk("s4_res0", 32'(res0), 32'h00);
        chk("s4_res1", 32'(res1), 32'h00);
        cycles(LAT + 3);
        req = 2'b00;
        chk("s4_fresh", 32'(res0), 32'h31);
        cycles(2);

        // req0 drops mid-operation after its operand changes
        drive(2'b01, 4'd5, 4'd3, 4'd0, 4'd0);
        cycles(2);
        mpd0 = 4'd7;
        cycles(1);
        req = 2'b00;
        cycles(6);
        chk("s5_res0", 32'(res0), 32'h0F);

        // randomized traffic
        for (int unsigned i = 0; i < 2000; i++) begin
            @(negedge clock);
            reset_n = ($urandom_range(0, 399) != 0);
            for (int unsigned r = 0; r < 2; r++) begin
                if (ack[r]) begin
                    if ($urandom_range(0, 1) == 0) req[r] = 1'b0;
                end else if (!req[r]) begin
                    if ($urandom_range(0, 2) == 0) req[r] = 1'b1;
                end else if ($urandom_range(0, 31) == 0) begin
                    req[r] = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) begin
                    if (r == 0) begin
                        mpd0 = W'($urandom);
                        mpr0 = W'($urandom);
                    end else begin
                        mpd1 = W'($urandom);
                        mpr1 = W'($urandom);
                    end
                end
            end
        end

        // drain: every expected completion must have been seen
        reset_n = 1'b1;
        req     = 2'b00;
        cycles(LAT + 4);
        chk("drain_pending", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, operand width of the shared Booth multiplier.
REQ-002 Parameter LATENCY, default 5, number of cycles mul_enable is held high before mul_res is valid.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 req  input  2  request per requester; held high until the matching ack.
REQ-006 mpd0, mpr0  input  WIDTH each  requester 0 multiplicand and multiplier, two's complement.
REQ-007 mpd1, mpr1  input  WIDTH each  requester 1 multiplicand and multiplier, two's complement.
REQ-008 ack  output  2  one-cycle completion pulse per requester.
REQ-009 res0, res1  output  2*WIDTH each  last product delivered to each requester.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 mul_enable  output  1  drives the multiplier enable input.
REQ-012 mul_mpd, mul_mpr  output  WIDTH each  operands to the multiplier.
REQ-013 mul_res  input  2*WIDTH  multiplier product.

Function
REQ-014 The FSM shall have states IDLE, LOAD, RUN and DONE, with exactly one active at a time.
REQ-015 In IDLE with any req bit high, the block shall grant one requester, capture that requester's operands into mul_mpd/mul_mpr and go to LOAD on the next edge.
REQ-016 Arbitration shall be round-robin with a 1-bit priority pointer, reset to requester 0.
REQ-017 The pointer shall move to the non-granted requester on exit from DONE.
REQ-018 When a single req bit is high, that requester shall be granted regardless of the pointer.
REQ-019 LOAD shall last one cycle with mul_enable low, so the multiplier reloads, then go to RUN.
REQ-020 RUN shall hold mul_enable high for exactly LATENCY cycles, counted by a down-counter of clog2(LATENCY+1) bits, then go to DONE.
REQ-021 On the RUN to DONE edge, mul_res shall be registered into res0 or res1 of the granted requester only; the other result shall hold.
REQ-022 In DONE, ack of the granted requester shall be high for exactly one cycle, mul_enable shall be low, and the next state shall be IDLE.
REQ-023 Timing: req sampled high in IDLE at edge 0 gives ack high in cycle LATENCY+2 and res valid from that cycle; there are no back-to-back grants, so the minimum period is LATENCY+3 cycles.
REQ-024 mul_mpd and mul_mpr shall stay stable from LOAD through DONE; requester operand changes after grant shall be ignored.
REQ-025 If a req bit falls mid-operation, the operation shall still complete, with res updated and ack pulsed.
REQ-026 A req bit still high in IDLE after its ack shall count as a new request.
REQ-027 A request arriving while busy shall wait, unlatched, until IDLE.

Reset
REQ-028 While reset_n is low at an edge, the block shall enter IDLE and clear the pointer, counter, ack, res0, res1, mul_enable, mul_mpd and mul_mpr to 0; busy shall follow the state and be 0.
REQ-029 A reset mid-operation shall abort the operation with no ack and no res update; operation resumes on the first edge after reset_n returns high.

Structure
REQ-030 The state encoding (IDLE=0, LOAD=1, RUN=2, DONE=3) and the default WIDTH/LATENCY constants shall reside in the shared package booth_ctrl_pkg.
REQ-031 Round-robin selection shall be a sub-module rr_arb2 (inputs req[1:0] and ptr; output one-hot grant); the counter and FSM shall stay in booth_mul_arbiter.

Verification
REQ-032 Scenario: req=01, mpd0=3, mpr0=5, model product 0x0F -> ack[0] pulses in cycle 7 (LATENCY=5), res0=8'h0F, res1 unchanged.
REQ-033 Scenario: req=10, mpd1=4'hD (-3), mpr1=2 -> res1=8'hFA; then mpd1=8, mpr1=8 (-8*-8) -> res1=8'h40.
REQ-034 Scenario: req=11 held from reset -> grants alternate 0,1,0,1 across four operations, with ack pulses separated by 8 cycles.
REQ-035 Scenario: reset_n low for one cycle during RUN -> no ack, res0/res1=0, busy=0, then a fresh grant.
REQ-036 Scenario: req0 dropped in cycle 3 and mpd0 changed in cycle 2 -> ack[0] still pulses, and res0 reflects the operands captured at grant.
